// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// multicycle_control_fsm: RV32I multicycle control unit driving the shared ALU/memory datapath.
// Revision 1.0
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_q;
  state_t     state_d;
  logic       funct3_ok;
  logic       op_legal;
  logic       pc_update;
  logic       branch;
  logic [2:0] alu_funct;

  assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  // Only R/I opcodes carry a funct3 that can make an otherwise known opcode illegal.
  always_comb begin
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_JAL: op_legal = 1'b1;
      OP_R, OP_I:                   op_legal = funct3_ok;
      default:                      op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = funct3_ok ? EXECR : FETCH;
          OP_I:         state_d = funct3_ok ? EXECI : FETCH;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:             state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:            state_d = MEMWB;
      EXECR, EXECI, JAL:  state_d = ALUWB;
      default:            state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Subtract only for R-type with funct7b5; I-type addi ignores instr[30].
  always_comb begin
    case (funct3)
      3'b000:  alu_funct = (op[5] && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_funct = 3'b101;
      3'b110:  alu_funct = 3'b011;
      3'b111:  alu_funct = 3'b010;
      default: alu_funct = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = 3'b000;
    illegal_instr = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      DECODE: begin
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b01;
        illegal_instr = ~op_legal;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_funct;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_funct;
      end
      ALUWB: RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        branch     = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    // Enables must drop the instant reset rises, before the state register is seen to change.
    if (reset) begin
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      illegal_instr = 1'b0;
      pc_update     = 1'b0;
      branch        = 1'b0;
    end
  end

  assign PCWrite = pc_update | (branch & Zero);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// tb_multicycle_control_fsm: randomized instructions checked against an instruction-level model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int vectors     = 0;
  int miscompares = 0;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [6:0] o, input logic [2:0] f3);
    logic f3_ok;
    f3_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    case (o)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return f3_ok ? C_R : C_ILL;
      7'b0010011: return f3_ok ? C_I : C_ILL;
      7'b1100011: return C_BEQ;
      7'b1101111: return C_JAL;
      default:    return C_ILL;
    endcase
  endfunction

  // ALU operation the instruction semantically needs: 0 add, 1 sub, 2 and, 3 or, 5 slt.
  function automatic logic [2:0] alu_needed(input int cls, input logic [2:0] f3, input logic f7);
    if (cls == C_BEQ) return 3'd1;
    if (cls == C_R || cls == C_I) begin
      case (f3)
        3'd0:    return (cls == C_R && f7) ? 3'd1 : 3'd0;
        3'd2:    return 3'd5;
        3'd6:    return 3'd3;
        default: return 3'd2;
      endcase
    end
    return 3'd0;
  endfunction

  // Entered at a falling edge with the FSM in FETCH; leaves at the falling edge where it is back in FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int         cls;
    int         path[$];
    int         pcw = 0, regw = 0, memw = 0, irw = 0, last_rw = -1;
    bit         writes_rd;
    logic [1:0] exp_imm;
    cls = classify(o, f3);
    case (cls)
      C_LW:    path = '{0, 1, 2, 3, 4};
      C_SW:    path = '{0, 1, 2, 5};
      C_R:     path = '{0, 1, 6, 8};
      C_I:     path = '{0, 1, 7, 8};
      C_BEQ:   path = '{0, 1, 9};
      C_JAL:   path = '{0, 1, 10, 8};
      default: path = '{0, 1};
    endcase
    writes_rd = (cls == C_LW) || (cls == C_R) || (cls == C_I) || (cls == C_JAL);
    case (cls)
      C_SW:    exp_imm = 2'b01;
      C_BEQ:   exp_imm = 2'b10;
      C_JAL:   exp_imm = 2'b11;
      default: exp_imm = 2'b00;
    endcase
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    for (int k = 0; k < path.size(); k++) begin
      #1;
      check("state", 32'(state), 32'(path[k]));
      pcw  += int'(PCWrite);
      regw += int'(RegWrite);
      memw += int'(MemWrite);
      irw  += int'(IRWrite);
      if (RegWrite) begin
        last_rw = k;
        check("wb_result_src", 32'(ResultSrc), (cls == C_LW) ? 32'd1 : 32'd0);
      end
      if (k == 0) begin
        check("fetch_pcwrite", 32'(PCWrite), 32'd1);
        check("fetch_srcb", 32'(ALUSrcB), 32'd2);
      end
      if (k == 1) begin
        check("illegal", 32'(illegal_instr), (cls == C_ILL) ? 32'd1 : 32'd0);
        check("immsrc", 32'(ImmSrc), 32'(exp_imm));
      end
      if (k == 2) begin
        check("aluctl", 32'(ALUControl), 32'(alu_needed(cls, f3, f7)));
        if (cls == C_BEQ) check("beq_pcwrite", 32'(PCWrite), 32'(z));
      end
      if (k == 3 && (cls == C_LW || cls == C_SW)) check("mem_adrsrc", 32'(AdrSrc), 32'd1);
      @(negedge clk);
    end
    check("irwrite_cnt", 32'(irw), 32'd1);
    check("pcwrite_cnt", 32'(pcw), 32'(1 + int'(cls == C_JAL) + int'(cls == C_BEQ && z)));
    check("regwrite_cnt", 32'(regw), writes_rd ? 32'd1 : 32'd0);
    check("regwrite_last", 32'(last_rw), writes_rd ? 32'(path.size() - 1) : 32'hFFFF_FFFF);
    check("memwrite_cnt", 32'(memw), (cls == C_SW) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [6:0] rop;
    reset = 1'b1; op = 7'b0100011; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_enables", 32'({PCWrite, MemWrite, IRWrite, RegWrite, illegal_instr}), 32'd0);
      check("rst_state", 32'(state), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("post_rst_irwrite", 32'(IRWrite), 32'd1);
    check("post_rst_pcwrite", 32'(PCWrite), 32'd1);
    check("post_rst_srcb", 32'(ALUSrcB), 32'd2);

    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0);
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);
    run_instr(7'b0110011, 3'd7, 1'b0, 1'b0);
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0);
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0);
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0);
    run_instr(7'b0110011, 3'd1, 1'b0, 1'b0);

    // Abort a store while it is writing memory.
    op = 7'b0100011; funct3 = 3'd2; Zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("memwrite_before_abort", 32'(MemWrite), 32'd1);
    check("state_before_abort", 32'(state), 32'd5);
    reset = 1'b1;
    #1;
    check("abort_memwrite", 32'(MemWrite), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_pcwrite", 32'(PCWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1100011;
        5: rop = 7'b1101111;
        6: rop = 7'($urandom);
        default: rop = 7'b1111111;
      endcase
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
